// File: rtl/mist_loader.sv
// mist_loader: routes a MiST data_io download to one of CHANNELS core memories.
// Incoming bytes are packed into WW-bit words, queued in a DEPTH-word FIFO and
// written out through a request/accept port that may stall.
module mist_loader #(
  parameter int CHANNELS = 4,
  parameter int AW       = 27,
  parameter int WW       = 8,
  parameter int DEPTH    = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dioE,
  input  logic [7:0]                     dioI,
  input  logic [AW-1:0]                  dioA,
  input  logic [7:0]                     dioD,
  input  logic                           dioW,
  input  logic [31:0]                    dioS,
  output logic [CHANNELS-1:0]            busy,
  output logic [CHANNELS-1:0]            done,
  output logic [31:0]                    size,
  output logic                           ovf,
  output logic [AW-$clog2(WW/8)-1:0]     memA,
  output logic [WW-1:0]                  memD,
  output logic [WW/8-1:0]                memM,
  output logic                           memW,
  input  logic                           memK
);

  localparam int BW  = WW / 8;          // bytes per word
  localparam int LB  = $clog2(BW);      // byte-lane address bits
  localparam int MAW = AW - LB;         // word address width
  localparam int PW  = $clog2(DEPTH);   // FIFO pointer width
  localparam int CW  = PW + 1;          // FIFO occupancy width
  localparam int EW  = MAW + WW + BW;   // FIFO entry: {addr, data, mask}

  localparam logic [BW-1:0] MASK_FULL = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CHANNELS-1:0] busy_q, busy_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [31:0]         size_q, size_d;
  logic                ovf_q, ovf_d;
  logic [MAW-1:0]      pk_addr_q, pk_addr_d;
  logic [WW-1:0]       pk_data_q, pk_data_d;
  logic [BW-1:0]       pk_mask_q, pk_mask_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic [EW-1:0]       fifo_mem [DEPTH];

  logic                in_lane;
  logic [MAW-1:0]      in_addr;
  logic [WW-1:0]       in_data;
  logic [BW-1:0]       in_mask;
  logic                start_ok;
  logic [CHANNELS-1:0] start_hot;
  logic                fifo_full;
  logic                push_req, push, pop;
  logic [EW-1:0]       push_word;
  logic                conflict;
  logic [BW-1:0]       m_mask;
  logic [WW-1:0]       m_data;
  logic [EW-1:0]       head;

  // Decode the incoming byte into word address, lane, positioned data and mask.
  always_comb begin
    in_lane   = (LB == 0) ? 1'b0 : dioA[0];
    in_addr   = dioA[AW-1:LB];
    in_data   = WW'(dioD) << {in_lane, 3'b000};
    in_mask   = BW'(1) << in_lane;
    start_ok  = dioE && (dioI != 8'd0) && (dioI <= 8'(CHANNELS));
    start_hot = CHANNELS'(1) << (dioI - 8'd1);
    fifo_full = (count_q == CW'(DEPTH));
    pop       = (count_q != '0) && memK;
  end

  // Download sequencing and byte packing; a refused push drops the incoming
  // byte and keeps the pack register intact.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statement can infer a latch.
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = '0;
    size_d    = size_q;
    ovf_d     = ovf_q;
    pk_addr_d = pk_addr_q;
    pk_data_d = pk_data_q;
    pk_mask_d = pk_mask_q;
    push_req  = 1'b0;
    push_word = '0;
    conflict  = 1'b0;
    m_mask    = pk_mask_q | in_mask;
    m_data    = pk_data_q | in_data;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          busy_d  = start_hot;
          size_d  = dioS;
          ovf_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (dioW) begin
          conflict = (pk_mask_q != '0) &&
                     ((pk_addr_q != in_addr) || ((pk_mask_q & in_mask) != '0));
          if (conflict) begin
            // Flush the partial word; the new byte opens a fresh pack.
            push_req  = 1'b1;
            push_word = {pk_addr_q, pk_data_q, pk_mask_q};
            if (!fifo_full) begin
              pk_addr_d = in_addr;
              pk_data_d = in_data;
              pk_mask_d = in_mask;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (m_mask == MASK_FULL) begin
            push_req  = 1'b1;
            push_word = {in_addr, m_data, m_mask};
            if (!fifo_full) begin
              pk_data_d = '0;
              pk_mask_d = '0;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            pk_addr_d = in_addr;
            pk_data_d = m_data;
            pk_mask_d = m_mask;
          end
        end
        if (!dioE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pk_mask_q != '0) begin
          push_req  = 1'b1;
          push_word = {pk_addr_q, pk_data_q, pk_mask_q};
          if (!fifo_full) begin
            pk_data_d = '0;
            pk_mask_d = '0;
          end
        end else if (count_q == '0) begin
          done_d  = busy_q;
          busy_d  = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; a full FIFO refuses pushes even
  // when a pop happens in the same cycle.
  always_comb begin
    push     = push_req && !fifo_full;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Control and pack state registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= '0;
      done_q    <= '0;
      size_q    <= '0;
      ovf_q     <= 1'b0;
      pk_addr_q <= '0;
      pk_data_q <= '0;
      pk_mask_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      size_q    <= size_d;
      ovf_q     <= ovf_d;
      pk_addr_q <= pk_addr_d;
      pk_data_q <= pk_data_d;
      pk_mask_q <= pk_mask_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; the occupancy
    // counter decides validity and the outputs are gated while empty.
    if (push) fifo_mem[wr_ptr_q] <= push_word;
  end

  // Present the FIFO head; zero whenever no write is requested.
  always_comb begin
    head = fifo_mem[rd_ptr_q];
    memW = (count_q != '0);
    memA = memW ? head[EW-1:WW+BW] : '0;
    memD = memW ? head[WW+BW-1:BW] : '0;
    memM = memW ? head[BW-1:0]     : '0;
    busy = busy_q;
    done = done_q;
    size = size_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_mist_loader.sv
// Bench for mist_loader: an 8-bit and a 16-bit instance share the ioctl bus;
// each has its own enable and accept. Expected memory writes are queued when
// bytes are driven and compared when the instance issues them.
module tb_mist_loader;

  typedef struct packed {
    logic [26:0] a;
    logic [15:0] d;
    logic [1:0]  m;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dioE8, dioE16;
  logic [7:0]  dioI, dioD;
  logic [26:0] dioA;
  logic        dioW;
  logic [31:0] dioS;
  logic        memK8, memK16;

  logic [3:0]  busy8, done8, busy16, done16;
  logic [31:0] size8, size16;
  logic        ovf8, ovf16;
  logic [26:0] memA8;
  logic [7:0]  memD8;
  logic [0:0]  memM8;
  logic        memW8;
  logic [25:0] memA16;
  logic [15:0] memD16;
  logic [1:0]  memM16;
  logic        memW16;

  int tests = 0;
  int fails = 0;
  int w8_cnt = 0, d8_cnt = 0, w16_cnt = 0, d16_cnt = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  always #5 clk = ~clk;

  mist_loader #(.CHANNELS(4), .AW(27), .WW(8), .DEPTH(8)) u_dut8 (
    .clock(clk), .reset(reset), .dioE(dioE8), .dioI(dioI), .dioA(dioA),
    .dioD(dioD), .dioW(dioW), .dioS(dioS), .busy(busy8), .done(done8),
    .size(size8), .ovf(ovf8), .memA(memA8), .memD(memD8), .memM(memM8),
    .memW(memW8), .memK(memK8)
  );

  mist_loader #(.CHANNELS(4), .AW(27), .WW(16), .DEPTH(8)) u_dut16 (
    .clock(clk), .reset(reset), .dioE(dioE16), .dioI(dioI), .dioA(dioA),
    .dioD(dioD), .dioW(dioW), .dioS(dioS), .busy(busy16), .done(done16),
    .size(size16), .ovf(ovf16), .memA(memA16), .memD(memD16), .memM(memM16),
    .memW(memW16), .memK(memK16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: count activity and compare every accepted write.
  always @(negedge clk) begin
    if (memW8) w8_cnt++;
    if (done8 != '0) d8_cnt++;
    if (memW16) w16_cnt++;
    if (done16 != '0) d16_cnt++;
    if (memW8 && memK8) begin
      check("wr8_expected", q8.size() != 0, 1'b1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check("wr8_addr", memA8, e8.a);
        check("wr8_data", memD8, e8.d[7:0]);
        check("wr8_mask", memM8, e8.m[0]);
      end
    end
    if (memW16 && memK16) begin
      check("wr16_expected", q16.size() != 0, 1'b1);
      if (q16.size() != 0) begin
        e16 = q16.pop_front();
        check("wr16_addr", memA16, e16.a[25:0]);
        check("wr16_data", memD16 & {{8{e16.m[1]}}, {8{e16.m[0]}}},
              e16.d & {{8{e16.m[1]}}, {8{e16.m[0]}}});
        check("wr16_mask", memM16, e16.m);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [26:0] a, input logic [7:0] d);
    dioA = a;
    dioD = d;
    dioW = 1'b1;
    tick();
    dioW = 1'b0;
  endtask

  task automatic push8(input logic [26:0] a, input logic [7:0] d);
    q8.push_back('{a: a, d: {8'h00, d}, m: 2'b01});
  endtask

  task automatic push16(input logic [26:0] a, input logic [15:0] d, input logic [1:0] m);
    q16.push_back('{a: a, d: d, m: m});
  endtask

  // Wait (bounded) for the done pulse, then check its shape and the held size.
  task automatic wait_done(input bit w16, input logic [3:0] exp_done, input logic [31:0] exp_size);
    int n = 0;
    logic [3:0] d;
    do begin
      @(negedge clk);
      d = w16 ? done16 : done8;
      n++;
    end while (d == '0 && n < 200);
    check("done_seen", d, exp_done);
    check("done_busy_clear", w16 ? busy16 : busy8, 4'b0000);
    check("done_size", w16 ? size16 : size8, exp_size);
    @(negedge clk);
    check("done_one_cycle", w16 ? done16 : done8, 4'b0000);
    check("size_after_done", w16 ? size16 : size8, exp_size);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ws, ds;
    reset = 1'b1; dioE8 = 1'b0; dioE16 = 1'b0; dioI = '0; dioA = '0;
    dioD = '0; dioW = 1'b0; dioS = '0; memK8 = 1'b1; memK16 = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_busy", busy8, 4'b0000);
    check("rst_done", done8, 4'b0000);
    check("rst_size", size8, 32'h0);
    check("rst_ovf", ovf8, 1'b0);
    check("rst_memW", memW8, 1'b0);
    check("rst_memA", memA8, 27'h0);
    check("rst_memD", memD8, 8'h00);
    check("rst_memM", memM8, 1'b0);
    check("rst_memW16", memW16, 1'b0);

    // Basic 8-bit download to channel 1, with size latching
    dioI = 8'd2; dioS = 32'h0000_4000; dioE8 = 1'b1;
    tick();
    check("t1_busy", busy8, 4'b0010);
    check("t1_size", size8, 32'h0000_4000);
    push8(27'd0, 8'hAA);
    send(27'd0, 8'hAA);
    check("t1_latency", memW8, 1'b1);
    dioS = 32'hDEAD_BEEF;
    push8(27'd1, 8'hBB);
    send(27'd1, 8'hBB);
    check("t1_size_mid", size8, 32'h0000_4000);
    dioE8 = 1'b0;
    wait_done(1'b0, 4'b0010, 32'h0000_4000);
    repeat (3) tick();
    check("t6_size_held", size8, 32'h0000_4000);
    check("t1_q_empty", q8.size(), 0);

    // 16-bit packing, trailing partial word
    dioI = 8'd1; dioS = 32'h0000_0003; dioE16 = 1'b1;
    tick();
    check("t2_busy", busy16, 4'b0001);
    push16(27'd0, 16'h2211, 2'b11);
    send(27'd0, 8'h11);
    send(27'd1, 8'h22);
    check("t2_latency", memW16, 1'b1);
    push16(27'd1, 16'h0033, 2'b01);
    send(27'd2, 8'h33);
    dioE16 = 1'b0;
    wait_done(1'b1, 4'b0001, 32'h0000_0003);

    // 16-bit: lane order swapped, then a repeated lane forces a partial push
    dioI = 8'd4; dioS = 32'h0000_0020; dioE16 = 1'b1;
    tick();
    check("t2b_busy", busy16, 4'b1000);
    push16(27'd3, 16'h7788, 2'b11);
    send(27'd7, 8'h77);
    send(27'd6, 8'h88);
    push16(27'd4, 16'h0099, 2'b01);
    send(27'd8, 8'h99);
    push16(27'd4, 16'h00AA, 2'b01);
    send(27'd8, 8'hAA);
    dioE16 = 1'b0;
    wait_done(1'b1, 4'b1000, 32'h0000_0020);
    check("t2b_q_empty", q16.size(), 0);

    // Overflow with a stalled memory port
    memK8 = 1'b0; dioI = 8'd1; dioS = 32'h0000_0900; dioE8 = 1'b1;
    tick();
    check("t3_ovf_cleared", ovf8, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push8(27'(i), 8'h10 + 8'(i));
      send(27'(i), 8'h10 + 8'(i));
    end
    check("t3_ovf", ovf8, 1'b1);
    check("t3_memW", memW8, 1'b1);
    check("t3_memA", memA8, 27'd0);
    check("t3_memD", memD8, 8'h10);
    repeat (3) tick();
    check("t3_memA_held", memA8, 27'd0);
    check("t3_memD_held", memD8, 8'h10);
    ws = w8_cnt;
    memK8 = 1'b1; dioE8 = 1'b0;
    wait_done(1'b0, 4'b0001, 32'h0000_0900);
    check("t3_q_empty", q8.size(), 0);
    check("t3_write_cycles", w8_cnt - ws, 8);
    check("t3_ovf_held", ovf8, 1'b1);

    // Invalid indices are ignored entirely
    ws = w8_cnt; ds = d8_cnt;
    dioS = 32'h0000_7777; dioI = 8'd0; dioE8 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send(27'(i), 8'h50);
    dioI = 8'd5;
    tick();
    for (int i = 0; i < 3; i++) send(27'(i), 8'h60);
    tick();
    check("t4_busy", busy8, 4'b0000);
    check("t4_no_write", w8_cnt - ws, 0);
    dioE8 = 1'b0;
    repeat (4) tick();
    check("t4_no_done", d8_cnt - ds, 0);
    check("t4_size_kept", size8, 32'h0000_0900);
    check("t4_ovf_kept", ovf8, 1'b1);

    // Reset in the middle of a download
    memK8 = 1'b0; dioI = 8'd3; dioS = 32'h0000_0123; dioE8 = 1'b1;
    tick();
    check("t5_busy", busy8, 4'b0100);
    for (int i = 0; i < 3; i++) send(27'(i), 8'hC0 + 8'(i));
    check("t5_pending", memW8, 1'b1);
    dioE8 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_memW", memW8, 1'b0);
    check("t5_busy_rst", busy8, 4'b0000);
    check("t5_ovf_rst", ovf8, 1'b0);
    check("t5_size_rst", size8, 32'h0);
    ws = w8_cnt; ds = d8_cnt;
    memK8 = 1'b1;
    repeat (10) tick();
    check("t5_no_write", w8_cnt - ws, 0);
    check("t5_no_done", d8_cnt - ds, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
